// File: rtl/uart_boot_loader.sv
// Boot loader: parses framed bytes from the RX FIFO, writes 32-bit words to RAM,
// acknowledges each frame through the TX FIFO and releases the core on an empty frame.
module uart_boot_loader #(
    parameter int unsigned ADDR_W      = 13,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_empty,
    input  logic [7:0]        rx_q,
    output logic              rx_rdreq,
    input  logic              tx_full,
    output logic              tx_wrreq,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_we,
    output logic              core_run,
    output logic              busy
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       STAT_OK  = 8'h4B;
    localparam logic [7:0]       STAT_ERR = 8'h45;
    localparam logic [7:0]       STAT_TMO = 8'h54;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_ACK
    } state_t;

    state_t            state, state_next;
    logic              started;
    logic              pending;
    logic              consume;
    logic              in_frame;
    logic              timeout;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [1:0]        hdr_idx;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       len;
    logic [15:0]       word_idx;
    logic [15:0]       word_idx_inc;
    logic [23:0]       word_buf;
    logic [7:0]        csum;
    logic [7:0]        status;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        consume      = pending;
        in_frame     = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
        timeout      = in_frame && !consume && (tmo_cnt == TMO_LAST);
        word_idx_inc = word_idx + 16'd1;
        // One read outstanding at most: a request is only issued once the previous byte is consumed.
        rx_rdreq     = started && !core_run && !pending && !rx_empty && (state != ST_ACK);
        case (state)
            ST_IDLE: begin
                if (consume && (rx_q == SYNC_BYTE)) state_next = ST_HDR;
            end
            ST_HDR: begin
                if (consume) begin
                    if (hdr_idx == 2'd3) begin
                        state_next = ({rx_q, len[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
                    end
                end else if (timeout) begin
                    state_next = ST_ACK;
                end
            end
            ST_DATA: begin
                if (consume) begin
                    if ((byte_idx == 2'd3) && (word_idx_inc == len)) state_next = ST_CSUM;
                end else if (timeout) begin
                    state_next = ST_ACK;
                end
            end
            ST_CSUM: begin
                if (consume || timeout) state_next = ST_ACK;
            end
            ST_ACK: begin
                if (!tx_full) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started  <= 1'b0;
            pending  <= 1'b0;
            tmo_cnt  <= '0;
            hdr_idx  <= '0;
            byte_idx <= '0;
            addr     <= '0;
            len      <= '0;
            word_idx <= '0;
            word_buf <= '0;
            csum     <= '0;
            status   <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            tx_wrreq <= 1'b0;
            tx_data  <= '0;
            core_run <= 1'b0;
        end else begin
            started  <= 1'b1;
            pending  <= rx_rdreq;
            ram_we   <= 1'b0;
            tx_wrreq <= 1'b0;
            if (consume || !in_frame) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (consume && (rx_q == SYNC_BYTE)) begin
                        csum    <= '0;
                        hdr_idx <= '0;
                    end
                end
                ST_HDR: begin
                    if (consume) begin
                        csum     <= csum ^ rx_q;
                        hdr_idx  <= hdr_idx + 2'd1;
                        word_idx <= '0;
                        byte_idx <= '0;
                        case (hdr_idx)
                            2'd0:    addr[7:0] <= rx_q;
                            2'd1:    addr      <= ADDR_W'({rx_q, addr[7:0]});
                            2'd2:    len[7:0]  <= rx_q;
                            default: len[15:8] <= rx_q;
                        endcase
                    end else if (timeout) begin
                        status <= STAT_TMO;
                    end
                end
                ST_DATA: begin
                    if (consume) begin
                        csum     <= csum ^ rx_q;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_q;
                            2'd1: word_buf[15:8]  <= rx_q;
                            2'd2: word_buf[23:16] <= rx_q;
                            default: begin
                                ram_we   <= 1'b1;
                                ram_addr <= addr + word_idx[ADDR_W-1:0];
                                ram_data <= {rx_q, word_buf};
                                word_idx <= word_idx_inc;
                            end
                        endcase
                    end else if (timeout) begin
                        status <= STAT_TMO;
                    end
                end
                ST_CSUM: begin
                    if (consume) begin
                        if (rx_q == csum) begin
                            status <= STAT_OK;
                            if (len == 16'd0) core_run <= 1'b1;
                        end else begin
                            status <= STAT_ERR;
                        end
                    end else if (timeout) begin
                        status <= STAT_TMO;
                    end
                end
                ST_ACK: begin
                    if (!tx_full) begin
                        tx_wrreq <= 1'b1;
                        tx_data  <= status;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
